// File: rtl/rv_core_pkg.sv
// Shared definitions for the RV32 core front end.
//   XLEN           : address/data width
//   NOP_INSTR      : addi x0,x0,0, used as filler for faulting fetches
//   ifetch_state_t : fetch FSM state encoding
//   ifetch_entry_t : one instruction-queue entry {instr, pc, err}
package rv_core_pkg;

   localparam int XLEN = 32;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      WAIT    = 2'd2,
      DISCARD = 2'd3
   } ifetch_state_t;

   typedef struct packed {
      logic [31:0]     instr;
      logic [XLEN-1:0] pc;
      logic            err;
   } ifetch_entry_t;

   function automatic logic is_misaligned(input logic [XLEN-1:0] pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/ifetch_queue.sv
// Small circular instruction queue between fetch and decode.
//   clk, rst_n  : clock, async active-low reset
//   push        : write push_entry at the tail
//   push_entry  : entry to write
//   pop         : consume the head (ignored when empty)
//   flush       : empty the queue; overrides push and pop in the same cycle
//   count       : number of valid entries
//   head        : entry at the head, read straight from storage
// DEPTH is expected to be a power of two so the pointers wrap naturally.
module ifetch_queue
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              push,
   input  ifetch_entry_t     push_entry,
   input  logic              pop,
   input  logic              flush,
   output logic [CNT_W-1:0]  count,
   output ifetch_entry_t     head
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   ifetch_entry_t     mem_q [DEPTH];
   logic [PTR_W-1:0]  rd_ptr_q;
   logic [PTR_W-1:0]  wr_ptr_q;
   logic [CNT_W-1:0]  count_q;
   logic              do_push;
   logic              do_pop;

   assign do_push = push && !flush;
   assign do_pop  = pop && (count_q != '0) && !flush;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else if (flush) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_entry;
            wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_q <= count_q + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count_q <= count_q - CNT_W'(1);
         end
      end
   end

   assign count = count_q;
   assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch stage: samples the PC, fetches one word at a time over a
// req/gnt/rvalid port and queues the results for decode.
//   clk, rst_n          : clock, async active-low reset
//   pc_i                : current PC from the PC stage
//   redirect_i          : control-flow change; flushes queue and in-flight fetch
//   pc_advance_o        : one-cycle pulse telling the PC stage to step
//   imem_req_o/addr_o   : memory request and its byte address
//   imem_gnt_i          : request accepted (may coincide with req)
//   imem_rvalid_i/rdata_i : response
//   instr_valid_o/instr_o/instr_pc_o/instr_err_o : queue head to decode
//   instr_ready_i       : decode consumes the head
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | nothing outstanding; decide whether to fetch or fault the PC
// REQ     | request driven, waiting for gnt
// WAIT    | request granted, waiting for rvalid
// DISCARD | granted request was flushed; drop its rvalid when it arrives
module ifetch_unit
   import rv_core_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [XLEN-1:0]  pc_i,
   input  logic             redirect_i,
   output logic             pc_advance_o,
   output logic             imem_req_o,
   output logic [XLEN-1:0]  imem_addr_o,
   input  logic             imem_gnt_i,
   input  logic             imem_rvalid_i,
   input  logic [31:0]      imem_rdata_i,
   output logic             instr_valid_o,
   output logic [31:0]      instr_o,
   output logic [XLEN-1:0]  instr_pc_o,
   output logic             instr_err_o,
   input  logic             instr_ready_i
);

   ifetch_state_t     state_q;
   ifetch_state_t     state_d;
   logic [XLEN-1:0]   fetch_pc_q;
   logic [XLEN-1:0]   fetch_pc_d;
   logic              adv_q;
   logic [CNT_W-1:0]  count;
   ifetch_entry_t     head;
   ifetch_entry_t     push_entry;
   logic              push;
   logic              pop;
   logic              room_idle;
   logic              room_after_rsp;

   assign pop       = instr_ready_i && instr_valid_o;
   assign room_idle = count < CNT_W'(DEPTH);
   // A response is being pushed this cycle, so re-issuing straight from WAIT
   // needs space for one more entry beyond it.
   assign room_after_rsp = pop || (count < CNT_W'(DEPTH - 1));

   always_comb begin
      state_d      = state_q;
      fetch_pc_d   = fetch_pc_q;
      push         = 1'b0;
      push_entry   = '0;
      pc_advance_o = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (!redirect_i && room_idle) begin
               if (is_misaligned(pc_i)) begin
                  // adv_q keeps back-to-back misaligned PCs from pulsing
                  // pc_advance_o on consecutive cycles.
                  if (!adv_q) begin
                     push         = 1'b1;
                     push_entry   = '{instr: NOP_INSTR, pc: pc_i, err: 1'b1};
                     pc_advance_o = 1'b1;
                  end
               end else begin
                  fetch_pc_d = pc_i;
                  state_d    = REQ;
               end
            end
         end
         REQ: begin
            if (imem_gnt_i) begin
               if (redirect_i) begin
                  state_d = DISCARD;
               end else begin
                  state_d      = WAIT;
                  pc_advance_o = 1'b1;
               end
            end else if (redirect_i) begin
               state_d = IDLE;
            end
         end
         WAIT: begin
            if (redirect_i) begin
               state_d = imem_rvalid_i ? IDLE : DISCARD;
            end else if (imem_rvalid_i) begin
               push       = 1'b1;
               push_entry = '{instr: imem_rdata_i, pc: fetch_pc_q, err: 1'b0};
               // Misaligned PCs are only handled from IDLE.
               if (room_after_rsp && !is_misaligned(pc_i)) begin
                  fetch_pc_d = pc_i;
                  state_d    = REQ;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DISCARD: begin
            if (imem_rvalid_i) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         fetch_pc_q <= '0;
         adv_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         fetch_pc_q <= fetch_pc_d;
         adv_q      <= pc_advance_o;
      end
   end

   ifetch_queue #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_queue (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_entry (push_entry),
      .pop        (pop),
      .flush      (redirect_i),
      .count      (count),
      .head       (head)
   );

   assign imem_req_o    = (state_q == REQ);
   assign imem_addr_o   = fetch_pc_q;
   assign instr_valid_o = (count != '0);
   assign instr_o       = head.instr;
   assign instr_pc_o    = head.pc;
   assign instr_err_o   = head.err;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction-fetch stage directly downstream of the program-counter register in the RV32 single-cycle core. It samples the current PC, issues a word request to the instruction memory port over a req/gnt/rvalid handshake, and buffers returned instructions in a 2-entry queue for decode. A `pc_advance_o` pulse tells the PC stage when to step. Redirects (taken branch/jump) flush the queue and discard any in-flight response.

## Interface
- `XLEN`, 32: address/data width.
- `DEPTH`, 2: instruction queue entries; the design only needs to support 2.
- `clk` in 1: clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `pc_i` in XLEN: current PC from the PC stage.
- `redirect_i` in 1: control-flow change this cycle (PC stage `pc_sel`).
- `pc_advance_o` out 1: one-cycle pulse; the PC stage may load its next value.
- `imem_req_o` out 1: memory request.
- `imem_addr_o` out XLEN: request byte address, equal to the latched PC.
- `imem_gnt_i` in 1: request accepted; may be high in the same cycle as req.
- `imem_rvalid_i` in 1: response valid.
- `imem_rdata_i` in 32: response instruction word.
- `instr_valid_o` out 1: queue head valid.
- `instr_o` out 32: head instruction.
- `instr_pc_o` out XLEN: PC of the head instruction.
- `instr_err_o` out 1: head entry came from a misaligned PC.
- `instr_ready_i` in 1: decode consumes the head.

## Operation
- FSM states:
  - IDLE: no request outstanding.
  - REQ: `imem_req_o`=1, waiting for gnt.
  - WAIT: granted, waiting for rvalid.
  - DISCARD: granted request was flushed; wait for its rvalid and drop it.
- IDLE→REQ: when `count + outstanding < DEPTH` and `redirect_i`=0.
  - Latch `pc_i` into `fetch_pc`; drive `imem_addr_o`=`fetch_pc`.
- Misaligned PC (`pc_i[1:0]`≠0) in IDLE:
  - Issue no request.
  - Push an entry with `instr_err_o`=1, `instr_o`=32'h00000013 (NOP).
  - Pulse `pc_advance_o`.
  - Stay in IDLE.
- REQ + gnt → WAIT: pulse `pc_advance_o` in the gnt cycle.
- REQ + redirect (no gnt): return to IDLE and drop the request; `imem_req_o` and `imem_addr_o` stay stable until gnt or redirect.
- WAIT + rvalid: push {rdata, fetch_pc, err=0}, then go to IDLE, or straight to REQ if the issue condition holds again.
- WAIT + redirect: go to DISCARD. If rvalid arrives in the same cycle, drop it and go to IDLE.
- DISCARD + rvalid: drop the data and go to IDLE.
- `imem_rvalid_i` in IDLE or REQ: ignore it.
- Redirect:
  - Flush the queue (count=0) in the same cycle; a pop in that cycle is also discarded.
  - Suppress `pc_advance_o` that cycle.
- Queue:
  - Circular buffer with 1-bit read/write pointers and a 2-bit count.
  - Push and pop in the same cycle leave count unchanged.
  - Push when full cannot occur because of the issue rule; the bench asserts this never happens.
- At most one outstanding request at any time.

## Timing
- Reset values:
  - FSM=IDLE, count=0.
  - `instr_valid_o`, `imem_req_o`, `pc_advance_o`, `instr_err_o` = 0.
  - `imem_addr_o`, `instr_o`, `instr_pc_o` = 0.
- Minimum latency with gnt in the same cycle as req and rvalid one cycle later:
  - cycle 0: IDLE decision.
  - cycle 1: REQ+gnt.
  - cycle 2: rvalid.
  - cycle 3: `instr_valid_o`=1.
- Queue outputs are registered from storage; there is no rvalid→instr_valid bypass.
- Sustained throughput is one instruction per 2 cycles with a 1-cycle memory, because only one request is outstanding.
- `pc_advance_o` is never high in two consecutive cycles.
- Reset mid-operation clears all state immediately; a late rvalid after reset is ignored because the FSM is in IDLE.

## Structure
- A shared `rv_core_pkg` holds:
  - `XLEN`.
  - `NOP_INSTR`=32'h00000013.
  - The FSM state enum `ifetch_state_t` {IDLE, REQ, WAIT, DISCARD}.
  - An entry struct {instr, pc, err}.
- One sub-module, `ifetch_queue`: parameterized FIFO with push/pop/flush, count, and head outputs.

## Test plan
- **Reset then straight-line fetch**: rst_n low→high, pc_i=0 then 4, memory with gnt=1 and 1-cycle rvalid returning 32'h00500093 then 32'h00100113, ready=1 → `instr_valid_o` rises in cycle 3 with instr/pc = 00500093/0, then 00100113/4; `pc_advance_o` pulses in cycles 1 and 3.
- **Backpressure**: ready=0 → queue fills after 2 instructions; no further `imem_req_o`; `pc_advance_o` stays low. Release ready → fetching resumes at the next PC.
- **Redirect during WAIT**: redirect_i=1 one cycle after gnt → DISCARD. That rvalid is dropped, the queue is empty, and the next request uses the new pc_i=32'h20.
- **Redirect coincident with rvalid**: redirect_i and rvalid in the same cycle, with 1 entry queued → `instr_valid_o`=0 next cycle, count=0.
- **Misaligned PC**: pc_i=32'h6 → no request; entry {13, 6, err=1} appears; `pc_advance_o` pulses once.
- **Delayed grant + async reset mid-WAIT**: gnt delayed 3 cycles, then reset asserted during WAIT → all outputs 0 immediately; a post-reset rvalid does not produce `instr_valid_o`.
